// File: rtl/misaligned_store_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// misaligned_store_sequencer_pkg
//   Shared LSU definitions for the misaligned store sequencer.
//   - seq_state_t : sequencer FSM state encoding (IDLE, BEAT0, BEAT1)
//   - SIZE_*      : store size encoding, log2 of the byte count
//   - max_size()  : largest legal store size for a given memory word width
// -----------------------------------------------------------------------------
package misaligned_store_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } seq_state_t;

   localparam logic [2:0] SIZE_B = 3'd0;
   localparam logic [2:0] SIZE_H = 3'd1;
   localparam logic [2:0] SIZE_W = 3'd2;
   localparam logic [2:0] SIZE_D = 3'd3;

   // A store may be no wider than one memory word.
   function automatic logic [2:0] max_size(input int wordlen);
      case (wordlen)
         8:       return SIZE_B;
         16:      return SIZE_H;
         32:      return SIZE_W;
         default: return SIZE_D;
      endcase
   endfunction

endpackage

// File: rtl/misaligned_store_sequencer_swbytemask.sv
// -----------------------------------------------------------------------------
// swbytemask
//   Byte-lane write mask for a store of 2**Size bytes at byte offset Adr
//   within a WORDLEN-bit word.
//   Parameters : WORDLEN  memory word width in bits
//                EXTEND   1 = also report lanes that spill into the next word
//   Ports      : Size             in  log2 of the store byte count
//                Adr              in  byte offset inside the word
//                ByteMask         out lanes written in the addressed word
//                ByteMaskExtended out lanes written in the following word
//                                     (zero when EXTEND=0)
// -----------------------------------------------------------------------------
module swbytemask #(
   parameter int WORDLEN = 64,
   parameter int EXTEND  = 0
) (
   input  logic [2:0]                     Size,
   input  logic [$clog2(WORDLEN/8)-1:0]   Adr,
   output logic [WORDLEN/8-1:0]           ByteMask,
   output logic [WORDLEN/8-1:0]           ByteMaskExtended
);

   localparam int NB = WORDLEN / 8;

   logic [2*NB-1:0] ones;
   logic [2*NB-1:0] shifted;

   // Contiguous run of 2**Size ones, clipped to one word, then moved to the
   // store offset inside a double-width window so spill lanes are kept.
   always_comb begin
      ones = '0;
      for (int i = 0; i < NB; i++) begin
         ones[i] = (i < (32'sd1 <<< Size));
      end
      shifted = ones << Adr;
   end

   assign ByteMask = shifted[NB-1:0];

   generate
      if (EXTEND != 0) begin : g_ext
         assign ByteMaskExtended = shifted[2*NB-1:NB];
      end else begin : g_noext
         assign ByteMaskExtended = '0;
      end
   endgenerate

endmodule

// File: rtl/misaligned_store_sequencer.sv
// -----------------------------------------------------------------------------
// misaligned_store_sequencer
//   Turns one LSU store request into one or two aligned memory write beats.
//   A store that crosses a WORDLEN/8-byte boundary is issued as two beats
//   (lower word then upper word); illegal sizes are dropped with an error pulse.
//
//   Handshakes: a transfer on either interface happens on the rising clk edge
//   where valid and ready are both high. Once MemValid is raised it stays high
//   with all Mem* outputs frozen until MemReady is seen; ReqReady may depend
//   combinationally on MemReady (so a new store can be taken in the same cycle
//   the final beat of the previous one is accepted).
//
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     ReqValid/ReqReady      store request handshake
//     ReqAdr, ReqSize        byte address, log2 byte count
//     ReqData                right-justified store data
//     ReqErr                 one-cycle pulse: illegal size, request dropped
//     MemValid/MemReady      write beat handshake
//     MemAdr, MemData        word-aligned address, lane-aligned data
//     MemByteMask, MemLast   byte enables, final beat of the store
//     Busy                   sequencer not idle
//     SplitCnt               saturating count of split stores
//     DbgState               current FSM state
// -----------------------------------------------------------------------------
module misaligned_store_sequencer
   import misaligned_store_sequencer_pkg::*;
#(
   parameter int WORDLEN = 64,
   parameter int ADRBITS = 32,
   parameter int CNTBITS = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ReqValid,
   output logic                   ReqReady,
   input  logic [ADRBITS-1:0]     ReqAdr,
   input  logic [2:0]             ReqSize,
   input  logic [WORDLEN-1:0]     ReqData,
   output logic                   ReqErr,
   output logic                   MemValid,
   input  logic                   MemReady,
   output logic [ADRBITS-1:0]     MemAdr,
   output logic [WORDLEN-1:0]     MemData,
   output logic [WORDLEN/8-1:0]   MemByteMask,
   output logic                   MemLast,
   output logic                   Busy,
   output logic [CNTBITS-1:0]     SplitCnt,
   output seq_state_t             DbgState
);

   localparam int NB   = WORDLEN / 8;
   localparam int OFFB = $clog2(NB);

   seq_state_t          state;

   // Second-beat payload, captured at accept and replayed in BEAT1.
   logic [ADRBITS-1:0]  hi_adr;
   logic [WORDLEN-1:0]  hi_data;
   logic [NB-1:0]       hi_mask;

   logic [OFFB-1:0]     req_off;
   logic [2*WORDLEN-1:0] req_wide;
   logic [NB-1:0]       req_mask_lo;
   logic [NB-1:0]       req_mask_hi;
   logic                req_split;
   logic [ADRBITS-1:0]  req_base;
   logic                req_illegal;

   logic                beat_done;
   logic                accept;
   logic                load_new;

   assign req_off     = ReqAdr[OFFB-1:0];
   assign req_wide    = {{WORDLEN{1'b0}}, ReqData} << {req_off, 3'b000};
   assign req_split   = |req_mask_hi;
   assign req_base    = {ReqAdr[ADRBITS-1:OFFB], {OFFB{1'b0}}};
   assign req_illegal = (ReqSize > max_size(WORDLEN));

   swbytemask #(
      .WORDLEN (WORDLEN),
      .EXTEND  (1)
   ) u_swbytemask (
      .Size             (ReqSize),
      .Adr              (req_off),
      .ByteMask         (req_mask_lo),
      .ByteMaskExtended (req_mask_hi)
   );

   assign beat_done = MemValid && MemReady;
   // Taking a request while the final beat completes gives back-to-back
   // stores with no idle cycle between them.
   assign ReqReady  = (state == IDLE) || (beat_done && MemLast);
   assign accept    = ReqValid && ReqReady;
   assign load_new  = accept && !req_illegal;

   assign Busy      = (state != IDLE);
   assign DbgState  = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         MemValid    <= 1'b0;
         MemLast     <= 1'b0;
         MemAdr      <= '0;
         MemData     <= '0;
         MemByteMask <= '0;
         ReqErr      <= 1'b0;
         SplitCnt    <= '0;
         hi_adr      <= '0;
         hi_data     <= '0;
         hi_mask     <= '0;
      end else begin
         ReqErr <= accept && req_illegal;

         // load_new can only be true in IDLE or on a final-beat handshake,
         // so it never interrupts a beat that still has work to do.
         if (load_new) begin
            state       <= BEAT0;
            MemValid    <= 1'b1;
            MemAdr      <= req_base;
            MemData     <= req_wide[WORDLEN-1:0];
            MemByteMask <= req_mask_lo;
            MemLast     <= !req_split;
            hi_adr      <= req_base + ADRBITS'(NB);
            hi_data     <= req_wide[2*WORDLEN-1:WORDLEN];
            hi_mask     <= req_mask_hi;
         end else begin
            case (state)
               BEAT0: begin
                  if (beat_done) begin
                     if (MemLast) begin
                        state    <= IDLE;
                        MemValid <= 1'b0;
                        MemLast  <= 1'b0;
                     end else begin
                        state       <= BEAT1;
                        MemAdr      <= hi_adr;
                        MemData     <= hi_data;
                        MemByteMask <= hi_mask;
                        MemLast     <= 1'b1;
                        if (SplitCnt != {CNTBITS{1'b1}}) begin
                           SplitCnt <= SplitCnt + CNTBITS'(1);
                        end
                     end
                  end
               end
               BEAT1: begin
                  if (beat_done) begin
                     state    <= IDLE;
                     MemValid <= 1'b0;
                     MemLast  <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_misaligned_store_sequencer.sv
// -----------------------------------------------------------------------------
// tb_misaligned_store_sequencer
//   Directed and randomized stores into a 64-bit sequencer (small split
//   counter so saturation is reached), plus a 32-bit instance for the
//   illegal-size case. Expected beats come from a byte-by-byte model.
// -----------------------------------------------------------------------------
module tb_misaligned_store_sequencer;
   import misaligned_store_sequencer_pkg::*;

   typedef struct {
      logic [31:0] adr;
      logic [63:0] data;
      logic [7:0]  mask;
      logic        last;
   } beat_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 64-bit instance ----------------
   logic        ReqValid, ReqReady, ReqErr, MemValid, MemReady, MemLast, Busy;
   logic [31:0] ReqAdr, MemAdr;
   logic [2:0]  ReqSize;
   logic [63:0] ReqData, MemData;
   logic [7:0]  MemByteMask;
   logic [3:0]  SplitCnt;
   seq_state_t  DbgState;

   misaligned_store_sequencer #(.WORDLEN(64), .ADRBITS(32), .CNTBITS(4)) dut (
      .clk(clk), .resetn(resetn),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAdr(ReqAdr),
      .ReqSize(ReqSize), .ReqData(ReqData), .ReqErr(ReqErr),
      .MemValid(MemValid), .MemReady(MemReady), .MemAdr(MemAdr),
      .MemData(MemData), .MemByteMask(MemByteMask), .MemLast(MemLast),
      .Busy(Busy), .SplitCnt(SplitCnt), .DbgState(DbgState)
   );

   // ---------------- 32-bit instance ----------------
   logic        v32, rdy32, err32, mv32, mr32, last32, busy32;
   logic [31:0] adr32, madr32, data32, mdata32;
   logic [2:0]  size32;
   logic [3:0]  mask32;
   logic [15:0] cnt32;
   seq_state_t  st32;

   misaligned_store_sequencer #(.WORDLEN(32), .ADRBITS(32), .CNTBITS(16)) dut32 (
      .clk(clk), .resetn(resetn),
      .ReqValid(v32), .ReqReady(rdy32), .ReqAdr(adr32),
      .ReqSize(size32), .ReqData(data32), .ReqErr(err32),
      .MemValid(mv32), .MemReady(mr32), .MemAdr(madr32),
      .MemData(mdata32), .MemByteMask(mask32), .MemLast(last32),
      .Busy(busy32), .SplitCnt(cnt32), .DbgState(st32)
   );

   // ---------------- scoreboard state ----------------
   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    split_exp = 0;
   logic  err_exp = 1'b0;
   logic  rand_ready = 1'b0;
   logic  prev_stall = 1'b0;
   beat_t prev_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: place each store byte at address adr+k and sort the bytes
   // into the word they land in.
   task automatic model_push(input logic [31:0] adr, input logic [2:0] size,
                             input logic [63:0] data);
      beat_t b0, b1;
      int    nb, off, lane;
      if (size > 3'd3) begin
         err_exp = 1'b1;
         return;
      end
      nb  = 1 << size;
      off = int'(adr[2:0]);
      b0  = '{adr: adr & ~32'h7, data: 64'h0, mask: 8'h0, last: 1'b1};
      b1  = '{adr: (adr & ~32'h7) + 32'd8, data: 64'h0, mask: 8'h0, last: 1'b1};
      for (int k = 0; k < nb; k++) begin
         lane = off + k;
         if (lane < 8) begin
            b0.data[8*lane +: 8] = data[8*k +: 8];
            b0.mask[lane]        = 1'b1;
         end else begin
            b1.data[8*(lane-8) +: 8] = data[8*k +: 8];
            b1.mask[lane-8]          = 1'b1;
            b0.last                  = 1'b0;
         end
      end
      exp_q.push_back(b0);
      if (!b0.last) exp_q.push_back(b1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!resetn) begin
         prev_stall = 1'b0;
      end else begin
         chk("mem_valid", 64'(MemValid), 64'(exp_q.size() != 0));
         chk("req_ready", 64'(ReqReady),
             64'((exp_q.size() == 0) || (exp_q.size() == 1 && MemReady)));
         chk("busy", 64'(Busy), 64'(exp_q.size() != 0));
         chk("req_err", 64'(ReqErr), 64'(err_exp));
         err_exp = 1'b0;
         chk("split_cnt", 64'(SplitCnt), 64'(split_exp));
         if (prev_stall) begin
            chk("hold_adr", 64'(MemAdr), 64'(prev_b.adr));
            chk("hold_data", MemData, prev_b.data);
            chk("hold_mask", 64'(MemByteMask), 64'(prev_b.mask));
            chk("hold_last", 64'(MemLast), 64'(prev_b.last));
         end
         if (exp_q.size() != 0 && MemValid) begin
            chk("beat_adr", 64'(MemAdr), 64'(exp_q[0].adr));
            chk("beat_data", MemData, exp_q[0].data);
            chk("beat_mask", 64'(MemByteMask), 64'(exp_q[0].mask));
            chk("beat_last", 64'(MemLast), 64'(exp_q[0].last));
            if (MemReady) begin
               if (!exp_q[0].last && split_exp != 15) split_exp++;
               exp_q.delete(0);
            end
         end
         prev_stall = MemValid && !MemReady;
         prev_b     = '{adr: MemAdr, data: MemData, mask: MemByteMask, last: MemLast};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) MemReady = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [31:0] adr, input logic [2:0] size, input logic [63:0] data);
      int n = 0;
      ReqValid = 1'b1;
      ReqAdr   = adr;
      ReqSize  = size;
      ReqData  = data;
      @(negedge clk);
      while (!ReqReady && n < 64) begin
         n++;
         tick();
         @(negedge clk);
      end
      if (!ReqReady) begin
         n_cmp++;
         n_err++;
         $error("FAIL accept_timeout observed=not_ready expected=ready");
         #1 ReqValid = 1'b0;
         return;
      end
      @(posedge clk);
      model_push(adr, size, data);
      #1;
      ReqValid = 1'b0;
      if (rand_ready) MemReady = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r_adr;
      logic [2:0]  r_size;
      logic [63:0] r_data;

      ReqValid = 1'b0; ReqAdr = '0; ReqSize = '0; ReqData = '0; MemReady = 1'b0;
      v32 = 1'b0; adr32 = '0; size32 = '0; data32 = '0; mr32 = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_valid", 64'(MemValid), 64'd0);
      chk("rst_mem_last", 64'(MemLast), 64'd0);
      chk("rst_mem_adr", 64'(MemAdr), 64'd0);
      chk("rst_mem_data", MemData, 64'd0);
      chk("rst_mem_mask", 64'(MemByteMask), 64'd0);
      chk("rst_req_err", 64'(ReqErr), 64'd0);
      chk("rst_split_cnt", 64'(SplitCnt), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_req_ready", 64'(ReqReady), 64'd1);
      @(posedge clk);
      #1 resetn = 1'b1;
      MemReady = 1'b1;

      // Misaligned doubleword
      send(32'h1005, SIZE_D, 64'h1122334455667788);
      @(negedge clk);
      chk("sd_b0_adr", 64'(MemAdr), 64'h1000);
      chk("sd_b0_mask", 64'(MemByteMask), 64'hE0);
      chk("sd_b0_data", MemData, 64'h6677880000000000);
      chk("sd_b0_last", 64'(MemLast), 64'd0);
      @(negedge clk);
      chk("sd_b1_adr", 64'(MemAdr), 64'h1008);
      chk("sd_b1_mask", 64'(MemByteMask), 64'h1F);
      chk("sd_b1_data", MemData, 64'h0000001122334455);
      chk("sd_b1_last", 64'(MemLast), 64'd1);
      drain();
      tick();
      chk("sd_split_cnt", 64'(SplitCnt), 64'd1);

      // Aligned word
      send(32'h2004, SIZE_W, 64'hDEADBEEF);
      @(negedge clk);
      chk("sw_adr", 64'(MemAdr), 64'h2000);
      chk("sw_mask", 64'(MemByteMask), 64'hF0);
      chk("sw_data", MemData, 64'hDEADBEEF00000000);
      chk("sw_last", 64'(MemLast), 64'd1);
      drain();
      tick();
      chk("sw_split_cnt", 64'(SplitCnt), 64'd1);

      // Address wrap
      send(32'hFFFFFFFF, SIZE_H, 64'hABCD);
      @(negedge clk);
      chk("wrap_b0_adr", 64'(MemAdr), 64'hFFFFFFF8);
      chk("wrap_b0_mask", 64'(MemByteMask), 64'h80);
      chk("wrap_b0_data", MemData, 64'hCD00000000000000);
      @(negedge clk);
      chk("wrap_b1_adr", 64'(MemAdr), 64'h0);
      chk("wrap_b1_mask", 64'(MemByteMask), 64'h01);
      chk("wrap_b1_data", MemData, 64'hAB);
      drain();
      tick();

      // Backpressure on beat0, then a byte store taken on the last handshake
      MemReady = 1'b0;
      send(32'h4006, SIZE_W, 64'h0A0B0C0D);
      repeat (3) tick();
      MemReady = 1'b1;
      send(32'h3003, SIZE_B, 64'h5A);
      @(negedge clk);
      chk("b2b_valid", 64'(MemValid), 64'd1);
      chk("b2b_adr", 64'(MemAdr), 64'h3000);
      chk("b2b_mask", 64'(MemByteMask), 64'h08);
      drain();
      tick();

      // Illegal sizes on the 64-bit instance
      send(32'h6000, 3'd5, 64'h1234);
      @(negedge clk);
      chk("ill64_err", 64'(ReqErr), 64'd1);
      chk("ill64_valid", 64'(MemValid), 64'd0);
      tick();

      // 32-bit instance: size 3 is illegal there
      v32 = 1'b1; adr32 = 32'h10; size32 = SIZE_D; data32 = 32'h12345678;
      @(negedge clk);
      chk("w32_ready", 64'(rdy32), 64'd1);
      @(posedge clk);
      #1 v32 = 1'b0;
      @(negedge clk);
      chk("w32_err_pulse", 64'(err32), 64'd1);
      chk("w32_no_valid", 64'(mv32), 64'd0);
      chk("w32_not_busy", 64'(busy32), 64'd0);
      @(negedge clk);
      chk("w32_err_once", 64'(err32), 64'd0);
      chk("w32_no_valid2", 64'(mv32), 64'd0);
      @(posedge clk);
      #1 v32 = 1'b1; adr32 = 32'h13; size32 = SIZE_H; data32 = 32'hABCD;
      @(posedge clk);
      #1 v32 = 1'b0;
      @(negedge clk);
      chk("w32_b0_adr", 64'(madr32), 64'h10);
      chk("w32_b0_mask", 64'(mask32), 64'h8);
      chk("w32_b0_data", 64'(mdata32), 64'hCD000000);
      @(negedge clk);
      chk("w32_b1_adr", 64'(madr32), 64'h14);
      chk("w32_b1_mask", 64'(mask32), 64'h1);
      chk("w32_b1_data", 64'(mdata32), 64'hAB);
      chk("w32_b1_last", 64'(last32), 64'd1);
      @(negedge clk);
      chk("w32_split_cnt", 64'(cnt32), 64'd1);
      tick();

      // Reset while the second beat is pending
      send(32'h5003, SIZE_D, 64'h0102030405060708);
      @(negedge clk);
      @(negedge clk);
      chk("mid_in_beat1", 64'(DbgState), 64'(BEAT1));
      #2;
      resetn = 1'b0;
      exp_q.delete();
      split_exp = 0;
      err_exp   = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(MemValid), 64'd0);
      chk("mid_rst_state", 64'(DbgState), 64'(IDLE));
      chk("mid_rst_busy", 64'(Busy), 64'd0);
      chk("mid_rst_cnt", 64'(SplitCnt), 64'd0);
      chk("mid_rst_mask", 64'(MemByteMask), 64'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // Randomized stores with random backpressure and gaps
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) r_adr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         else                           r_adr = $urandom;
         if ($urandom_range(0, 15) == 0) r_size = 3'($urandom_range(4, 7));
         else                            r_size = 3'($urandom_range(0, 3));
         r_data = {$urandom, $urandom};
         if (r_size < 3'd3) r_data = r_data & ((64'd1 << (8 << r_size)) - 64'd1);
         send(r_adr, r_size, r_data);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      rand_ready = 1'b0;
      MemReady = 1'b1;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
